// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program-memory geometry and the program-loader state encoding.
package cpu_pkg;

  localparam int PC_WIDTH    = 8;
  localparam int INSTR_WIDTH = 16;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHK,
    DONE,
    ERROR
  } ld_state_e;

endpackage

// File: rtl/prog_loader.sv
// Program-memory loader: assembles big-endian byte pairs into instruction words and
// writes them from address 0, holding the core stalled. PROG_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             byte_data,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   pm_write,
  output logic [PC_WIDTH-1:0]    pm_addr,
  output logic [INSTR_WIDTH-1:0] pm_wdata,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error,
  output logic [PC_WIDTH:0]      word_count
);

  localparam int          CW    = PC_WIDTH + 1;
  localparam logic [16:0] DEPTH = 17'(1) << PC_WIDTH;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam ld_state_e FIN_ST = CHK;
`else
  localparam ld_state_e FIN_ST = DONE;
`endif

  ld_state_e               state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [7:0]              hi_q, hi_d;
  logic                    byte_ready_q, byte_ready_d;
  logic                    pm_write_q, pm_write_d;
  logic [PC_WIDTH-1:0]     pm_addr_q, pm_addr_d;
  logic [INSTR_WIDTH-1:0]  pm_wdata_q, pm_wdata_d;
  logic                    cpu_hold_q, cpu_hold_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [CW-1:0]           word_count_q, word_count_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_new;

  assign accept  = byte_valid && byte_ready_q;
  assign len_new = {len_q[15:8], byte_data};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    hi_d         = hi_q;
    pm_write_d   = 1'b0;
    pm_addr_d    = pm_addr_q;
    pm_wdata_d   = pm_wdata_q;
    word_count_d = word_count_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
    if (accept) csum_d = csum_q ^ byte_data;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        // start wins over any byte offered here; byte_ready is low so nothing is consumed
        if (start) begin
          state_d      = LEN_HI;
          word_count_d = '0;
          pm_addr_d    = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      LEN_HI: if (accept) begin
        len_d[15:8] = byte_data;
        state_d     = LEN_LO;
      end
      LEN_LO: if (accept) begin
        len_d[7:0] = byte_data;
        if ({1'b0, len_new} > DEPTH) state_d = ERROR;
        else if (len_new == 16'd0)   state_d = FIN_ST;
        else                         state_d = DATA_HI;
      end
      DATA_HI: if (accept) begin
        hi_d    = byte_data;
        state_d = DATA_LO;
      end
      DATA_LO: if (accept) begin
        pm_wdata_d = INSTR_WIDTH'({hi_q, byte_data});
        pm_write_d = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        pm_addr_d    = pm_addr_q + PC_WIDTH'(1);
        word_count_d = word_count_q + CW'(1);
        if (17'(word_count_q) + 17'd1 == {1'b0, len_q}) state_d = FIN_ST;
        else                                             state_d = DATA_HI;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: if (accept) begin
        state_d = (byte_data == csum_q) ? DONE : ERROR;
      end
`endif
      default: state_d = IDLE;
    endcase

    // outputs are registered decodes of the next state
    byte_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA_HI) ||
                   (state_d == DATA_LO) || (state_d == CHK);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERROR);
    cpu_hold_d   = (state_d != DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      hi_q         <= '0;
      byte_ready_q <= 1'b0;
      pm_write_q   <= 1'b0;
      pm_addr_q    <= '0;
      pm_wdata_q   <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      hi_q         <= hi_d;
      byte_ready_q <= byte_ready_d;
      pm_write_q   <= pm_write_d;
      pm_addr_q    <= pm_addr_d;
      pm_wdata_q   <= pm_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign pm_write   = pm_write_q;
  assign pm_addr    = pm_addr_q;
  assign pm_wdata   = pm_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: builds byte streams from a word list, predicts the
// program-memory writes and final status, and compares against the DUT.
module tb_prog_loader;

  localparam int PCW   = 8;
  localparam int DEPTH = 1 << PCW;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      byte_data = 8'h00;
  logic            byte_valid = 1'b0;
  logic            byte_ready, pm_write, cpu_hold, done, error;
  logic [PCW-1:0]  pm_addr;
  logic [15:0]     pm_wdata;
  logic [PCW:0]    word_count;

  prog_loader dut (
    .clock(clock), .reset(reset), .start(start), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .pm_write(pm_write),
    .pm_addr(pm_addr), .pm_wdata(pm_wdata), .cpu_hold(cpu_hold), .done(done),
    .error(error), .word_count(word_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t wr_q[$];
  int  ready_in_write = 0;

  always @(negedge clock) begin
    cyc++;
    if (pm_write === 1'b1) begin
      wr_q.push_back('{int'(pm_addr), int'(pm_wdata), cyc});
      if (byte_ready !== 1'b0) ready_in_write++;
    end
  end

  // reference model state
  logic [7:0] b_q[$];
  int         words[$];
  int         exp_addr[$];
  int         exp_data[$];
  bit         exp_err;

  function automatic void build(input int n);
    logic [7:0] x;
    logic [15:0] w;
    b_q.delete(); exp_addr.delete(); exp_data.delete();
    w = 16'(n);
    b_q.push_back(w[15:8]);
    b_q.push_back(w[7:0]);
    exp_err = (n > DEPTH);
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        w = 16'(words[i]);
        b_q.push_back(w[15:8]);
        b_q.push_back(w[7:0]);
        exp_addr.push_back(i % DEPTH);
        exp_data.push_back(words[i]);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (b_q[i]) x = x ^ b_q[i];
      b_q.push_back(x);
`endif
    end
  endfunction

  function automatic void rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(int'($urandom_range(0, 65535)));
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // mode 0: valid held high, 1: one idle cycle between bytes, 2: random gaps
  task automatic send_stream(input int first, input int last, input int mode);
    for (int i = first; i <= last; i++) begin
      int gap;
      bit acc;
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      if (gap > 0) begin
        byte_valid = 1'b0;
        repeat (gap) @(negedge clock);
      end
      byte_data  = b_q[i];
      byte_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 30 && !acc; t++) begin
        acc = byte_ready;
        @(negedge clock);
      end
      if (!acc) begin
        n_chk++;
        $display("FAIL accept_timeout: byte %0d got ready=0 want 1", i);
        byte_valid = 1'b0;
        return;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done === 1'b1 || error === 1'b1) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    n_chk++;
    if (!(done === 1'b1 || error === 1'b1)) $display("FAIL end_timeout: got done=%0b error=%0b want one set", done, error);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_chk++;
    if ({byte_ready, pm_write, pm_addr, pm_wdata, cpu_hold, done, error, word_count} !==
        {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'h000})
      $display("FAIL reset_values: got rdy=%0b wr=%0b addr=%0h data=%0h hold=%0b done=%0b err=%0b wc=%0d",
               byte_ready, pm_write, pm_addr, pm_wdata, cpu_hold, done, error, word_count);
    else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_chk++;
    if (byte_ready !== 1'b0 || cpu_hold !== 1'b1) $display("FAIL idle_outputs: got rdy=%0b hold=%0b want 0 1", byte_ready, cpu_hold);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    words.delete(); words.push_back('h1234); words.push_back('hABCD);
    build(2);
    wr_q.delete(); ready_in_write = 0;
    pulse_start();
    n_chk++;
    if (byte_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) $display("FAIL b2b_started: got rdy=%0b hold=%0b done=%0b want 1 1 0", byte_ready, cpu_hold, done);
    else n_pass++;
    send_stream(0, b_q.size() - 1, 0);
    wait_end();
    n_chk++;
    if (wr_q.size() !== 2) $display("FAIL b2b_count: got %0d writes want 2", wr_q.size());
    else n_pass++;
    for (int i = 0; i < wr_q.size() && i < 2; i++) begin
      n_chk++;
      if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i])
        $display("FAIL b2b_write%0d: got addr %0h data %0h want %0h %0h", i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    if (wr_q.size() == 2) begin
      n_chk++;
      if (wr_q[1].cyc - wr_q[0].cyc !== 3) $display("FAIL b2b_spacing: got %0d cycles want 3", wr_q[1].cyc - wr_q[0].cyc);
      else n_pass++;
    end
    n_chk++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || word_count !== 9'd2 || ready_in_write !== 0)
      $display("FAIL b2b_final: got done=%0b hold=%0b err=%0b wc=%0d rdyw=%0d want 1 0 0 2 0", done, cpu_hold, error, word_count, ready_in_write);
    else n_pass++;
  endtask

  task automatic test_valid_toggle();
    words.delete(); words.push_back('h1234); words.push_back('hABCD);
    build(2);
    wr_q.delete(); ready_in_write = 0;
    pulse_start();
    n_chk++;
    if (done !== 1'b0 || word_count !== 9'd0 || pm_addr !== 8'd0 || cpu_hold !== 1'b1)
      $display("FAIL restart_clear: got done=%0b wc=%0d addr=%0d hold=%0b want 0 0 0 1", done, word_count, pm_addr, cpu_hold);
    else n_pass++;
    send_stream(0, b_q.size() - 1, 1);
    wait_end();
    n_chk++;
    if (wr_q.size() !== 2) $display("FAIL tog_count: got %0d writes want 2", wr_q.size());
    else n_pass++;
    for (int i = 0; i < wr_q.size() && i < 2; i++) begin
      n_chk++;
      if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i])
        $display("FAIL tog_write%0d: got addr %0h data %0h want %0h %0h", i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    n_chk++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 9'd2 || ready_in_write !== 0)
      $display("FAIL tog_final: got done=%0b hold=%0b wc=%0d rdyw=%0d want 1 0 2 0", done, cpu_hold, word_count, ready_in_write);
    else n_pass++;
  endtask

  task automatic test_overflow();
    words.delete();
    build(DEPTH + 1);
    wr_q.delete();
    pulse_start();
    send_stream(0, b_q.size() - 1, 0);
    wait_end();
    repeat (2) @(negedge clock);
    n_chk++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || byte_ready !== 1'b0 || wr_q.size() !== 0)
      $display("FAIL ovf_error: got err=%0b done=%0b hold=%0b rdy=%0b writes=%0d want 1 0 1 0 0", error, done, cpu_hold, byte_ready, wr_q.size());
    else n_pass++;
    rand_words(3);
    build(3);
    pulse_start();
    send_stream(0, b_q.size() - 1, 2);
    wait_end();
    n_chk++;
    if (done !== 1'b1 || error !== 1'b0 || wr_q.size() !== 3)
      $display("FAIL ovf_recover: got done=%0b err=%0b writes=%0d want 1 0 3", done, error, wr_q.size());
    else n_pass++;
    for (int i = 0; i < wr_q.size() && i < 3; i++) begin
      n_chk++;
      if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i])
        $display("FAIL ovf_write%0d: got addr %0h data %0h want %0h %0h", i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_full_depth();
    int bad;
    rand_words(DEPTH);
    build(DEPTH);
    wr_q.delete();
    pulse_start();
    send_stream(0, b_q.size() - 1, 0);
    wait_end();
    repeat (2) @(negedge clock);
    n_chk++;
    if (wr_q.size() !== DEPTH) $display("FAIL full_count: got %0d writes want %0d", wr_q.size(), DEPTH);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < wr_q.size() && i < DEPTH; i++)
      if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i]) bad++;
    n_chk++;
    if (bad !== 0) $display("FAIL full_data: got %0d bad writes want 0", bad);
    else n_pass++;
    n_chk++;
    if (done !== 1'b1 || pm_addr !== 8'd0 || word_count !== 9'(DEPTH))
      $display("FAIL full_final: got done=%0b addr=%0d wc=%0d want 1 0 %0d", done, pm_addr, word_count, DEPTH);
    else n_pass++;
  endtask

  task automatic test_zero_and_ignore();
    words.delete();
    build(0);
    wr_q.delete();
    pulse_start();
    send_stream(0, b_q.size() - 1, 0);
    wait_end();
    n_chk++;
    if (done !== 1'b1 || word_count !== 9'd0 || wr_q.size() !== 0 || cpu_hold !== 1'b0)
      $display("FAIL zero_len: got done=%0b wc=%0d writes=%0d hold=%0b want 1 0 0 0", done, word_count, wr_q.size(), cpu_hold);
    else n_pass++;
    rand_words(1);
    build(1);
    pulse_start();
    send_stream(0, 1, 0);
    pulse_start();
    n_chk++;
    if (byte_ready !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1)
      $display("FAIL ignore_start: got rdy=%0b done=%0b hold=%0b want 1 0 1", byte_ready, done, cpu_hold);
    else n_pass++;
    send_stream(2, b_q.size() - 1, 0);
    wait_end();
    n_chk++;
    if (wr_q.size() !== 1 || done !== 1'b1) $display("FAIL ignore_result: got writes=%0d done=%0b want 1 1", wr_q.size(), done);
    else if (wr_q[0].addr !== 0 || wr_q[0].data !== exp_data[0])
      $display("FAIL ignore_result: got addr %0h data %0h want 0 %0h", wr_q[0].addr, wr_q[0].data, exp_data[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int n;
      n = int'($urandom_range(1, 8));
      rand_words(n);
      build(n);
      wr_q.delete(); ready_in_write = 0;
      pulse_start();
      send_stream(0, b_q.size() - 1, 2);
      wait_end();
      n_chk++;
      if (wr_q.size() !== n) $display("FAIL rnd%0d_count: got %0d writes want %0d", it, wr_q.size(), n);
      else n_pass++;
      for (int i = 0; i < wr_q.size() && i < n; i++) begin
        n_chk++;
        if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i])
          $display("FAIL rnd%0d_write%0d: got addr %0h data %0h want %0h %0h", it, i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
        else n_pass++;
      end
      n_chk++;
      if (done !== 1'b1 || word_count !== 9'(n) || pm_addr !== 8'(n) || ready_in_write !== 0)
        $display("FAIL rnd%0d_final: got done=%0b wc=%0d addr=%0d rdyw=%0d want 1 %0d %0d 0", it, done, word_count, pm_addr, ready_in_write, n, n);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    words.delete(); words.push_back('h1234); words.push_back('hABCD);
    build(2);
    wr_q.delete();
    pulse_start();
    send_stream(0, 2, 0);
    byte_data  = b_q[3];
    byte_valid = 1'b1;
    reset      = 1'b0;
    #1;
    n_chk++;
    if ({byte_ready, pm_write, pm_addr, pm_wdata, cpu_hold, done, error, word_count} !==
        {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'h000})
      $display("FAIL midreset_values: got rdy=%0b wr=%0b addr=%0h data=%0h hold=%0b done=%0b err=%0b wc=%0d",
               byte_ready, pm_write, pm_addr, pm_wdata, cpu_hold, done, error, word_count);
    else n_pass++;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    byte_valid = 1'b0;
    n_chk++;
    if (wr_q.size() !== 0 || byte_ready !== 1'b0 || cpu_hold !== 1'b1)
      $display("FAIL midreset_quiet: got writes=%0d rdy=%0b hold=%0b want 0 0 1", wr_q.size(), byte_ready, cpu_hold);
    else n_pass++;
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    b_q.delete();
    b_q.push_back(8'h00); b_q.push_back(8'h01); b_q.push_back(8'h12); b_q.push_back(8'h34); b_q.push_back(8'h27);
    pulse_start();
    send_stream(0, 4, 0);
    wait_end();
    n_chk++;
    if (done !== 1'b1 || error !== 1'b0) $display("FAIL csum_good: got done=%0b err=%0b want 1 0", done, error);
    else n_pass++;
    b_q[4] = 8'h00;
    pulse_start();
    send_stream(0, 4, 0);
    wait_end();
    n_chk++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) $display("FAIL csum_bad: got err=%0b done=%0b hold=%0b want 1 0 1", error, done, cpu_hold);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_valid_toggle();
    test_overflow();
    test_full_depth();
    test_zero_and_ignore();
    test_random();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writer side of the program-memory interface that the control unit fetches from. Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words. Writes each word to program memory at sequential addresses starting from 0. Holds the CPU core stalled until the load completes.

Parameters:
PC_WIDTH, 8, program-memory address width; depth = 2**PC_WIDTH words.
INSTR_WIDTH, 16, instruction word width; fixed at 16 (two bytes per word).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (reset==0 resets the block).
start  input  1  one-cycle pulse; begins a load; honoured only in IDLE, DONE or ERROR.
byte_data  input  8  incoming stream byte.
byte_valid  input  1  byte_data is valid.
byte_ready  output  1  loader accepts a byte; transfer occurs when byte_valid && byte_ready at a rising edge.
pm_write  output  1  program-memory write strobe, one-cycle pulse per word.
pm_addr  output  PC_WIDTH  write address.
pm_wdata  output  16  write data.
cpu_hold  output  1  stalls the core (PC frozen, rf_write/mem_write suppressed downstream).
done  output  1  load completed successfully.
error  output  1  load aborted (length overflow or checksum mismatch).
word_count  output  PC_WIDTH+1  number of words written in the current load.

Behaviour:
- Reset values: byte_ready=0, pm_write=0, pm_addr=0, pm_wdata=0, cpu_hold=1, done=0, error=0, word_count=0, state=IDLE.
- An asynchronous reset mid-load aborts immediately. Words already written stay in memory; no further writes occur.
- Stream format: LEN_HI, LEN_LO (N, 16-bit big-endian), then N words, each sent high byte first, then low byte.
- States:
  - IDLE: on start, go to LEN_HI; clear done, error, word_count and pm_addr; set cpu_hold=1.
  - LEN_HI -> LEN_LO: latch the upper length byte.
  - LEN_LO: latch the lower length byte. If N > 2**PC_WIDTH, go to ERROR. If N == 0, go to DONE (or CHK when the feature is enabled). Otherwise go to DATA_HI.
  - DATA_HI -> DATA_LO: latch the high byte.
  - DATA_LO -> WRITE: latch the low byte.
  - WRITE: pm_write=1 for exactly one cycle with pm_wdata={hi,lo} and pm_addr = current index. The cycle after, increment pm_addr (mod 2**PC_WIDTH) and word_count. If word_count reaches N, go to DONE (or CHK). Otherwise go to DATA_HI.
  - DONE: done=1, cpu_hold=0; start restarts a load (back to LEN_HI).
  - ERROR: error=1, cpu_hold=1; only start or reset exits.
- byte_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK. It is 0 in IDLE, WRITE, DONE and ERROR, so a byte arriving during WRITE waits.
- byte_valid may drop between bytes; the FSM waits in the current state with no timeout.
- Minimum throughput: 3 cycles per word (2 accepts + 1 write).
- pm_addr wraps only after the final write of a full-depth load (N = 2**PC_WIDTH); no write occurs after the wrap.
- A start pulse in any other state is ignored. A simultaneous start and accepted byte in DONE: start wins and the byte is not consumed (byte_ready=0 in DONE).
- cpu_hold is a registered output; the core resumes the cycle after done rises.

Optional Feature:
PROG_LOADER_CHECKSUM_EN
- Defined: after the last word (or N==0), state CHK accepts one byte. A running XOR of all LEN and data bytes is compared with it; a match goes to DONE, a mismatch goes to ERROR. The checksum register clears on start.
- Undefined: no CHK state; the FSM goes straight to DONE; error is asserted only for length overflow.

Decomposition:
- Shared package cpu_pkg: the loader state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERROR), the INSTR_WIDTH constant, and PC_WIDTH so it matches the control unit.
- No sub-module is needed. The byte-pair assembler and the FSM fit in one module.

Test Plan:
- Reset low mid-stream after 3 of 6 data bytes -> all outputs return to reset values immediately; cpu_hold=1; no further pm_write.
- start; stream 00 02 12 34 AB CD with valid held high -> pm_write at addr 0 data 0x1234, then addr 1 data 0xABCD; done=1, cpu_hold=0, word_count=2; every write exactly 3 cycles apart.
- Same stream with byte_valid toggling every other cycle -> identical writes and values; byte_ready low during WRITE cycles.
- Length 01 01 (257) with PC_WIDTH=8 -> ERROR after LEN_LO; error=1, no pm_write, cpu_hold=1; a subsequent start with valid stream recovers to done=1.
- Length 00 00 -> done=1 with word_count=0 and no pm_write; start pulse in DATA_HI is ignored (state unchanged).
- With PROG_LOADER_CHECKSUM_EN: stream 00 01 12 34 then checksum 0x27 -> done=1; checksum 0x00 -> error=1, cpu_hold=1.
